pipe_stage_reg: RTL

//  Parametrised pipeline stage register; generic successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries a data bus and a control bus with a valid/ready handshake.
//  - Supports flush (branch/jump kill) and zero-control bubbles.
//  - Optional 2-entry skid buffer gives a registered in_ready at full throughput.
//  - Saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (data + ctrl, valid/ready) with optional 2-entry skid; 1-cycle latency.
// Backpressure: out_ready=0 holds the head; SKID=1 registers in_ready, SKID=0 passes out_ready through.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_ready_q;
    logic              accept;
    logic              emit;
    logic              main_ld_in;
    logic              main_ld_skid;
    logic              skid_ld;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign occupancy = state;

    // in_ready_q is 0 in reset for both variants, so nothing is taken before the first edge.
    assign in_ready = HAS_SKID ? in_ready_q
                               : (in_ready_q && (out_ready || state == EMPTY));

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        state_nxt    = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt  = ONE;
                    main_ld_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    main_ld_in = 1'b1;
                end else if (accept && HAS_SKID) begin
                    state_nxt = FULL;
                    skid_ld   = 1'b1;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    state_nxt    = ONE;
                    main_ld_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush kills held entries and any same-cycle accept; payload regs keep stale values.
        if (flush) begin
            state_nxt    = EMPTY;
            main_ld_in   = 1'b0;
            main_ld_skid = 1'b0;
            skid_ld      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (main_ld_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (main_ld_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (skid_ld) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
